// File: rtl/regfile_ctrl_pkg.sv
// Shared constants for the register-file write-back path: port widths,
// register count and the requester index assignment.
package regfile_ctrl_pkg;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_REG = 32;
  localparam int NUM_REQ = 3;

  // Requester slots on the write-back arbiter.
  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MUL  = 2;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, searching from the slot
// after the last winner. The pointer advances only when update is strobed.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int SUM_W = PTR_W + 1;

  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] nextPtr_s;
  logic [PTR_W-1:0] idx_s;
  logic [SUM_W-1:0] sum_s;
  logic [N-1:0]     grant_s;
  logic             found_s;

  // Scan requesters starting at the pointer; the first valid one wins.
  always_comb begin
    grant_s   = '0;
    nextPtr_s = ptr_r;
    found_s   = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = 0; k < N; k++) begin
      sum_s = {1'b0, ptr_r} + SUM_W'(k);
      if (sum_s >= SUM_W'(N)) begin
        sum_s = sum_s - SUM_W'(N);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (!found_s && req[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        found_s        = 1'b1;
        if (idx_s == PTR_W'(N - 1)) begin
          nextPtr_s = '0;
        end else begin
          nextPtr_s = idx_s + PTR_W'(1);
        end
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register: highest-priority slot for the next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (update) begin
      ptr_r <= nextPtr_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign grant = grant_s;

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Write-back scheduler for the 32x32 register file: arbitrates execution
// unit write-backs onto the single write port through one registered stage
// and keeps a per-register pending-write scoreboard for RAW/WAW stalls.
module regfile_wb_scheduler #(
  parameter int NUM_REQ = regfile_ctrl_pkg::NUM_REQ,
  parameter int DATA_W  = regfile_ctrl_pkg::DATA_W,
  parameter int ADDR_W  = regfile_ctrl_pkg::ADDR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_write,
  output logic [ADDR_W-1:0]         rf_wreg,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      issue_ready,
  input  logic [ADDR_W-1:0]         rd_addr1,
  input  logic [ADDR_W-1:0]         rd_addr2,
  output logic                      rd_busy1,
  output logic                      rd_busy2
);

  import regfile_ctrl_pkg::*;

  localparam int NUM_REGS = 1 << ADDR_W;

  logic [NUM_REQ-1:0]  grant_s;
  logic                anyGrant_s;
  logic [ADDR_W-1:0]   selAddr_s;
  logic [DATA_W-1:0]   selData_s;
  logic                issueFire_s;
  logic [NUM_REGS-1:0] busy_r;
  logic [NUM_REGS-1:0] busyNext_s;
  logic                rfWrite_r;
  logic [ADDR_W-1:0]   rfWreg_r;
  logic [DATA_W-1:0]   rfWdata_r;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req_valid),
    .update (anyGrant_s),
    .grant  (grant_s)
  );

  // The write port never back-pressures, so every grant is a completed handshake.
  assign req_ready  = grant_s;
  assign anyGrant_s = |grant_s;

  // Route the granted requester's address and data to the output stage.
  always_comb begin
    selAddr_s = '0;
    selData_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s[i]) begin
        selAddr_s = req_addr[i*ADDR_W +: ADDR_W];
        selData_s = req_data[i*DATA_W +: DATA_W];
      end else begin
        selAddr_s = selAddr_s;
      end
    end
  end

  // Output stage: writes to r0 complete the handshake but are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rfWrite_r <= 1'b0;
      rfWreg_r  <= '0;
      rfWdata_r <= '0;
    end else if (anyGrant_s && (selAddr_s != '0)) begin
      rfWrite_r <= 1'b1;
      rfWreg_r  <= selAddr_s;
      rfWdata_r <= selData_s;
    end else begin
      rfWrite_r <= 1'b0;
      rfWreg_r  <= rfWreg_r;
      rfWdata_r <= rfWdata_r;
    end
  end

  assign rf_write = rfWrite_r;
  assign rf_wreg  = rfWreg_r;
  assign rf_wdata = rfWdata_r;

  // WAW check reads the registered busy bits only; a same-cycle clear does not bypass.
  assign issue_ready = (issue_addr == '0) || !busy_r[issue_addr];
  assign issueFire_s = issue_valid && issue_ready && (issue_addr != '0);
  assign rd_busy1    = busy_r[rd_addr1];
  assign rd_busy2    = busy_r[rd_addr2];

  // Next scoreboard: clear on the retiring write, then set on issue so set wins.
  always_comb begin
    busyNext_s = busy_r;
    if (rfWrite_r) begin
      busyNext_s[rfWreg_r] = 1'b0;
    end else begin
      busyNext_s = busyNext_s;
    end
    if (issueFire_s) begin
      busyNext_s[issue_addr] = 1'b1;
    end else begin
      busyNext_s = busyNext_s;
    end
    busyNext_s[0] = 1'b0;
  end

  // Scoreboard register; all pending entries drop on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= '0;
    end else begin
      busy_r <= busyNext_s;
    end
  end

endmodule
